sharpen_window_gen: RTL and testbench

//  Upstream stage of the sharpening filter. Turns a raster RGB pixel stream into one

---
 rtl/sharpen_window_gen.sv | 149 ++++++++++++++
 tb/tb_sharpen_window_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sharpen_window_gen.sv
// sharpen_window_gen: raster RGB stream to zero-padded 3x3 windows per channel,
// with two line buffers per channel and an internal COLS+1 zero-pixel tail flush.
module sharpen_window_gen #(
    parameter int WIDTH     = 8,
    parameter int COLS      = 512,
    parameter int ROWS      = 512,
    parameter int LINE_BITS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       r_data_in,
    input  logic [WIDTH-1:0]       g_data_in,
    input  logic [WIDTH-1:0]       b_data_in,
    input  logic                   data_in_done,
    output logic [9*WIDTH-1:0]     win_r,
    output logic [9*WIDTH-1:0]     win_g,
    output logic [9*WIDTH-1:0]     win_b,
    output logic                   win_valid,
    output logic [LINE_BITS-1:0]   win_col,
    output logic [LINE_BITS-1:0]   win_row,
    output logic                   frame_done
);
    localparam int PW = 3*WIDTH;
    localparam int VW = 2*LINE_BITS+1;
    localparam int AW = $clog2(COLS);
    localparam logic [VW-1:0] LAST_IN   = VW'(ROWS*COLS-1);
    localparam logic [VW-1:0] FILL_END  = VW'(COLS);
    localparam logic [VW-1:0] FIRST_WIN = VW'(COLS+1);
    localparam logic [VW-1:0] LAST_V    = VW'(ROWS*COLS+COLS);
    localparam logic [LINE_BITS-1:0] CMAX = LINE_BITS'(COLS-1);
    localparam logic [LINE_BITS-1:0] RMAX = LINE_BITS'(ROWS-1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state_q, state_d;

    logic                 consume, emit, last_v;
    logic [VW-1:0]        vcnt_q, vcnt_d;
    logic [LINE_BITS-1:0] in_col_q, in_col_d, c_col_q, c_col_d, c_row_q, c_row_d;
    logic [PW-1:0]        lb0 [COLS];
    logic [PW-1:0]        lb1 [COLS];
    logic [PW-1:0]        pix, sel;
    logic [3*PW-1:0]      c1_q, c1_d, c2_q, c2_d, nc;
    logic [9*WIDTH-1:0]   win_r_q, win_r_d, win_g_q, win_g_d, win_b_q, win_b_d;
    logic                 win_valid_q, win_valid_d, frame_done_q, frame_done_d;
    logic [LINE_BITS-1:0] win_col_q, win_col_d, win_row_q, win_row_d;
    logic [AW-1:0]        idx;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FILL: if (data_in_done) state_d = vcnt_q == LAST_IN ? FLUSH : vcnt_q == FILL_END ? RUN : FILL;
            RUN:        if (data_in_done && vcnt_q == LAST_IN) state_d = FLUSH;
            FLUSH:      if (vcnt_q == LAST_V) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // vcnt_q is the index of the virtual pixel consumed on this edge
    always_comb begin
        consume = state_q == FLUSH || data_in_done;
        emit    = consume && vcnt_q >= FIRST_WIN;
        last_v  = state_q == FLUSH && vcnt_q == LAST_V;
    end

    always_comb begin
        idx      = in_col_q[AW-1:0];
        pix      = state_q == FLUSH ? '0 : {r_data_in, g_data_in, b_data_in};
        nc       = {pix, lb1[idx], lb0[idx]};
        vcnt_d   = last_v ? '0 : consume ? vcnt_q + 1'b1 : vcnt_q;
        in_col_d = last_v ? '0 : consume ? (in_col_q == CMAX ? '0 : in_col_q + 1'b1) : in_col_q;
        c_col_d  = emit ? (c_col_q == CMAX ? '0 : c_col_q + 1'b1) : c_col_q;
        c_row_d  = emit && c_col_q == CMAX ? (c_row_q == RMAX ? '0 : c_row_q + 1'b1) : c_row_q;
        c1_d     = consume ? c2_q : c1_q;
        c2_d     = consume ? nc : c2_q;
        win_valid_d  = emit;
        frame_done_d = last_v;
        win_col_d    = emit ? c_col_q : win_col_q;
        win_row_d    = emit ? c_row_q : win_row_q;
        win_r_d = win_r_q;
        win_g_d = win_g_q;
        win_b_d = win_b_q;
        sel     = '0;
        // column masking also hides the wrap-around from the neighbouring line
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                sel = dx == 0 ? c1_q[dy*PW +: PW] : dx == 1 ? c2_q[dy*PW +: PW] : nc[dy*PW +: PW];
                sel = (dy == 0 && c_row_q == '0) || (dy == 2 && c_row_q == RMAX) ||
                      (dx == 0 && c_col_q == '0) || (dx == 2 && c_col_q == CMAX) ? '0 : sel;
                if (emit) begin
                    win_r_d[(3*dy+dx)*WIDTH +: WIDTH] = sel[2*WIDTH +: WIDTH];
                    win_g_d[(3*dy+dx)*WIDTH +: WIDTH] = sel[WIDTH +: WIDTH];
                    win_b_d[(3*dy+dx)*WIDTH +: WIDTH] = sel[0 +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (consume) begin
            lb1[idx] <= pix;
            lb0[idx] <= lb1[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vcnt_q       <= '0;
            in_col_q     <= '0;
            c_col_q      <= '0;
            c_row_q      <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            win_r_q      <= '0;
            win_g_q      <= '0;
            win_b_q      <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
        end else begin
            vcnt_q       <= vcnt_d;
            in_col_q     <= in_col_d;
            c_col_q      <= c_col_d;
            c_row_q      <= c_row_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            win_r_q      <= win_r_d;
            win_g_q      <= win_g_d;
            win_b_q      <= win_b_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
        end
    end

    assign win_r      = win_r_q;
    assign win_g      = win_g_q;
    assign win_b      = win_b_q;
    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sharpen_window_gen.sv
// tb_sharpen_window_gen: directed checks of window contents, order, timing and framing
// on a 4x3 image.
module tb_sharpen_window_gen;
    localparam int W = 8, C = 4, R = 3, LB = 10;
    logic clk = 0, reset = 1, din = 0;
    logic [W-1:0] r_in = 0, g_in = 0, b_in = 0;
    logic [9*W-1:0] win_r, win_g, win_b;
    logic win_valid, frame_done;
    logic [LB-1:0] win_col, win_row;

    sharpen_window_gen #(.WIDTH(W), .COLS(C), .ROWS(R), .LINE_BITS(LB)) dut (
        .clk(clk), .reset(reset), .r_data_in(r_in), .g_data_in(g_in), .b_data_in(b_in),
        .data_in_done(din), .win_r(win_r), .win_g(win_g), .win_b(win_b),
        .win_valid(win_valid), .win_col(win_col), .win_row(win_row), .frame_done(frame_done));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9*W-1:0] r, g, b;
        logic [LB-1:0]  col, row;
        logic           fd;
    } win_t;
    win_t q[$];
    int total = 0, bad = 0, fdn = 0;

    always @(negedge clk) begin
        if (win_valid) q.push_back({win_r, win_g, win_b, win_col, win_row, frame_done});
        if (frame_done) fdn++;
    end

    task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [W-1:0] pv(input int ch, input int mode, input int off, input int p);
        return mode == 0 ? W'(p + off) : ch == 0 ? W'(p) : ch == 1 ? W'(p + 100) : W'(255 - p);
    endfunction

    function automatic logic [9*W-1:0] ew(input int ch, input int mode, input int off, input int cr, input int cc);
        logic [9*W-1:0] v = '0;
        for (int k = 0; k < 9; k++) begin
            int nr = cr + k/3 - 1, ncl = cc + k%3 - 1;
            if (nr >= 0 && nr < R && ncl >= 0 && ncl < C) v[k*W +: W] = pv(ch, mode, off, nr*C + ncl);
        end
        return v;
    endfunction

    task automatic send(input int mode, input int off, input int p, input int gap);
        r_in = pv(0, mode, off, p);
        g_in = pv(1, mode, off, p);
        b_in = pv(2, mode, off, p);
        din = 1;
        @(posedge clk); #1;
        din = 0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int mode, input int off, input int gap);
        for (int p = 0; p < R*C; p++) send(mode, off, p, gap);
    endtask

    task automatic wait_fd(input string tag, input int target);
        int n = 0;
        while (fdn < target && n < 60) begin @(posedge clk); #1; n++; end
        chk(tag, fdn, target);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_frame(input string tag, input int mode, input int off);
        for (int i = 0; i < R*C; i++) begin
            win_t e = q.size() > 0 ? q.pop_front() : '0;
            chk(tag, e, {ew(0, mode, off, i/C, i%C), ew(1, mode, off, i/C, i%C), ew(2, mode, off, i/C, i%C),
                         LB'(i%C), LB'(i/C), i == R*C-1});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk); #1;
        chk("rst_valid", win_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_col", win_col, 0);
        chk("rst_row", win_row, 0);
        chk("rst_data", {win_r, win_g, win_b}, 0);
        reset = 0;
        @(posedge clk); #1;

        q.delete(); fdn = 0;
        for (int p = 0; p < R*C; p++) begin
            send(0, 0, p, 0);
            chk("s1_valid_timing", win_valid, p >= C+1);
        end
        wait_fd("s1_done", 1);
        chk("s1_count", q.size(), 12);
        if (q.size() == 12) begin
            chk("s1_first", q[0].r, {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
            chk("s1_last", {q[11].r, q[11].row, q[11].col, q[11].fd},
                {8'd0, 8'd0, 8'd0, 8'd0, 8'd11, 8'd10, 8'd0, 8'd7, 8'd6, 10'd2, 10'd3, 1'b1});
        end
        check_frame("s1_win", 0, 0);

        q.delete(); fdn = 0;
        send_frame(0, 0, 3);
        wait_fd("s2_done", 1);
        chk("s2_count", q.size(), 12);
        check_frame("s2_win", 0, 0);

        q.delete(); fdn = 0;
        send_frame(1, 0, 0);
        wait_fd("s3_done", 1);
        chk("s3_count", q.size(), 12);
        if (q.size() == 12) begin
            chk("s3_r11", q[5].r, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
            chk("s3_b11", q[5].b, {8'd245, 8'd246, 8'd247, 8'd249, 8'd250, 8'd251, 8'd253, 8'd254, 8'd255});
        end
        check_frame("s3_win", 1, 0);

        for (int p = 0; p < 7; p++) send(0, 0, p, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("s4_rst_valid", win_valid, 0);
        chk("s4_rst_pos", {win_col, win_row, frame_done}, 0);
        q.delete(); fdn = 0;
        send_frame(0, 0, 0);
        wait_fd("s4_done", 1);
        chk("s4_count", q.size(), 12);
        check_frame("s4_win", 0, 0);

        q.delete(); fdn = 0;
        send_frame(0, 0, 0);
        r_in = 50; g_in = 50; b_in = 50; din = 1;
        repeat (6) @(posedge clk); #1;
        din = 0;
        for (int p = 1; p < R*C; p++) send(0, 50, p, 0);
        wait_fd("s5_done", 2);
        chk("s5_count", q.size(), 24);
        if (q.size() == 24)
            chk("s5_f2_first", {q[12].r, q[12].row, q[12].col},
                {8'd55, 8'd54, 8'd0, 8'd51, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 10'd0, 10'd0});
        check_frame("s5_f1", 0, 0);
        check_frame("s5_f2", 0, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
